// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
//   Shared definitions for the SD CMD-line response receiver.
//   - rx_state_e  : receiver state encoding
//   - FRAME_LEN   : length of a short (R1-style) response frame in bits
//   - CRC_LEN     : width of the CRC7 field
//   - CRC7_POLY   : low-order taps of x^7 + x^3 + 1
//   - crc7_step() : one serial MSB-first CRC7 update
// -----------------------------------------------------------------------------
package sd_pkg;

  localparam int FRAME_LEN = 48;
  localparam int CRC_LEN   = 7;
  localparam logic [CRC_LEN-1:0] CRC7_POLY = 7'h09;

  // Start, transmission, index and argument bits that precede the CRC field.
  localparam int RESP_LEN  = FRAME_LEN - CRC_LEN - 1;
  localparam int BIT_CNT_W = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    RECV       = 2'd2,
    DONE       = 2'd3
  } rx_state_e;

  // Feedback is the register MSB XOR the incoming bit; when set, the
  // polynomial taps are folded into the shifted register.
  function automatic logic [CRC_LEN-1:0] crc7_step(input logic [CRC_LEN-1:0] crc,
                                                   input logic               din);
    logic fb;
    fb = crc[CRC_LEN-1] ^ din;
    return {crc[CRC_LEN-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
  endfunction

endpackage

// File: rtl/crc7_serial.sv
// -----------------------------------------------------------------------------
// crc7_serial
//   Bit-serial CRC7 (x^7 + x^3 + 1, initial value 0, MSB first).
//   Ports:
//     clk     : clock
//     rst_ni  : asynchronous active-low reset, clears the register
//     clr     : synchronous clear, takes priority over en
//     en      : fold bit_in into the register this cycle
//     bit_in  : serial data bit ('bit' itself is a reserved word)
//     crc     : current CRC register contents
// -----------------------------------------------------------------------------
module crc7_serial
  import sd_pkg::*;
(
  input  logic               clk,
  input  logic               rst_ni,
  input  logic               clr,
  input  logic               en,
  input  logic               bit_in,
  output logic [CRC_LEN-1:0] crc
);

  logic [CRC_LEN-1:0] crc_d;
  logic [CRC_LEN-1:0] crc_q;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = crc7_step(crc_q, bit_in);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_rx.sv
// -----------------------------------------------------------------------------
// sd_cmd_rx
//   Receives one 48-bit SD response from the CMD line per en_i pulse.
//   After arming, waits up to TIMEOUT_CYC high samples for the start bit,
//   then shifts in the remaining 47 bits MSB first, checks CRC7 over bits
//   0..39 and checks the transmission (0) and end (1) bits.
//   Ports:
//     clk_i       : clock, cmd_i sampled on the rising edge
//     rst_ni      : asynchronous active-low reset
//     en_i        : one-cycle arm pulse, honoured only while idle
//     cmd_i       : serial CMD line, idle high
//     busy_o      : armed or receiving
//     resp_o      : frame bits 0..39 (start, transmission, index, argument)
//     crc_o       : received CRC7 field (bits 40..46)
//     crc_ok_o    : computed CRC7 matches crc_o
//     frame_err_o : transmission bit not 0 or end bit not 1
//     valid_o     : one-cycle pulse, result outputs updated
//     timeout_o   : one-cycle pulse, no start bit within TIMEOUT_CYC samples
//   Result outputs hold their last value until the next valid_o.
// -----------------------------------------------------------------------------
module sd_cmd_rx
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                cmd_i,
  output logic                busy_o,
  output logic [RESP_LEN-1:0] resp_o,
  output logic [CRC_LEN-1:0]  crc_o,
  output logic                crc_ok_o,
  output logic                frame_err_o,
  output logic                valid_o,
  output logic                timeout_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int SR_W  = FRAME_LEN - 1;

  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_LEN - 1);
  localparam logic [BIT_CNT_W-1:0] CRC_END  = BIT_CNT_W'(RESP_LEN);

  rx_state_e            state_d,     state_q;
  logic [TMO_W-1:0]     tmo_cnt_d,   tmo_cnt_q;
  logic [BIT_CNT_W-1:0] bit_cnt_d,   bit_cnt_q;
  // Holds frame bits 0..46; bit 0 ends up in the MSB once bit 46 is in.
  logic [SR_W-1:0]      sr_d,        sr_q;
  logic [RESP_LEN-1:0]  resp_d,      resp_q;
  logic [CRC_LEN-1:0]   crc_fld_d,   crc_fld_q;
  logic                 crc_ok_d,    crc_ok_q;
  logic                 frame_err_d, frame_err_q;
  logic                 valid_d,     valid_q;
  logic                 timeout_d,   timeout_q;
  logic                 busy_d,      busy_q;

  logic                 crc_clr;
  logic                 crc_en;
  logic [CRC_LEN-1:0]   crc_calc;

  crc7_serial u_crc7 (
    .clk    (clk_i),
    .rst_ni (rst_ni),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (cmd_i),
    .crc    (crc_calc)
  );

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    resp_d      = resp_q;
    crc_fld_d   = crc_fld_q;
    crc_ok_d    = crc_ok_q;
    frame_err_d = frame_err_q;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d   = WAIT_START;
          tmo_cnt_d = '0;
          crc_clr   = 1'b1;
        end
      end

      WAIT_START: begin
        if (!cmd_i) begin
          // Start bit is frame bit 0 and is part of the CRC coverage.
          state_d   = RECV;
          bit_cnt_d = BIT_CNT_W'(1);
          sr_d      = {sr_q[SR_W-2:0], cmd_i};
          crc_en    = 1'b1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = IDLE;
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      RECV: begin
        crc_en = (bit_cnt_q < CRC_END);
        if (bit_cnt_q == BIT_LAST) begin
          // cmd_i is the end bit; sr_q already holds bits 0..46.
          state_d     = DONE;
          resp_d      = sr_q[SR_W-1 -: RESP_LEN];
          crc_fld_d   = sr_q[CRC_LEN-1:0];
          crc_ok_d    = (crc_calc == sr_q[CRC_LEN-1:0]);
          frame_err_d = sr_q[SR_W-2] | ~cmd_i;
          valid_d     = 1'b1;
        end else begin
          sr_d      = {sr_q[SR_W-2:0], cmd_i};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: the frame shift register is a plain flop bank, so it is reset along
  // with the rest; an aborted frame leaves nothing behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      tmo_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      resp_q      <= '0;
      crc_fld_q   <= '0;
      crc_ok_q    <= 1'b0;
      frame_err_q <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      resp_q      <= resp_d;
      crc_fld_q   <= crc_fld_d;
      crc_ok_q    <= crc_ok_d;
      frame_err_q <= frame_err_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
    end
  end

  assign busy_o      = busy_q;
  assign resp_o      = resp_q;
  assign crc_o       = crc_fld_q;
  assign crc_ok_o    = crc_ok_q;
  assign frame_err_o = frame_err_q;
  assign valid_o     = valid_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_sd_cmd_rx.sv
// -----------------------------------------------------------------------------
// tb_sd_cmd_rx
//   Directed bench for sd_cmd_rx. Each sent frame pushes its expected result
//   (from an independent CRC7 model) onto a scoreboard queue; the result is
//   popped and compared when valid_o appears.
// -----------------------------------------------------------------------------
module tb_sd_cmd_rx;

  localparam int TIMEOUT_CYC = 64;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic        cmd_i;
  logic        busy_o;
  logic [39:0] resp_o;
  logic [6:0]  crc_o;
  logic        crc_ok_o;
  logic        frame_err_o;
  logic        valid_o;
  logic        timeout_o;

  sd_cmd_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .cmd_i       (cmd_i),
    .busy_o      (busy_o),
    .resp_o      (resp_o),
    .crc_o       (crc_o),
    .crc_ok_o    (crc_ok_o),
    .frame_err_o (frame_err_o),
    .valid_o     (valid_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [39:0] resp;
    logic [6:0]  crc;
    logic        crc_ok;
    logic        frame_err;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   valid_cnt = 0;
  int   timeout_cnt = 0;

  always @(negedge clk_i) begin
    if (valid_o) valid_cnt++;
    if (timeout_o) timeout_cnt++;
    if (valid_o || timeout_o) begin
      total++;
      assert (!(valid_o && timeout_o)) else begin
        bad++;
        $error("FAIL overlap observed valid=%0b timeout=%0b expected not both", valid_o, timeout_o);
      end
    end
  end

  function automatic logic [6:0] crc7_model(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic arm(input int pre);
    en_i = 1'b1;
    tick();
    en_i = 1'b0;
    cmd_i = 1'b1;
    check("busy_armed", 64'(busy_o), 64'd1);
    repeat (pre) tick();
  endtask

  task automatic send_bits(input logic [47:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      cmd_i = frame[47 - i];
      tick();
    end
    cmd_i = 1'b1;
  endtask

  task automatic send_frame(input logic [39:0] resp, input logic [6:0] crc,
                            input logic eb, input int pre);
    exp_t e;
    e.resp      = resp;
    e.crc       = crc;
    e.crc_ok    = (crc7_model(resp) == crc);
    e.frame_err = resp[38] | ~eb;
    sb_q.push_back(e);
    arm(pre);
    send_bits({resp, crc, eb}, 48);
  endtask

  task automatic expect_valid(input string tag);
    int   waited;
    exp_t e;
    waited = 0;
    while (!valid_o && waited < 8) begin
      tick();
      waited++;
    end
    check({tag, ".latency"}, 64'(waited), 64'd0);
    e = '0;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    check({tag, ".resp"},      64'(resp_o),      64'(e.resp));
    check({tag, ".crc"},       64'(crc_o),       64'(e.crc));
    check({tag, ".crc_ok"},    64'(crc_ok_o),    64'(e.crc_ok));
    check({tag, ".frame_err"}, 64'(frame_err_o), 64'(e.frame_err));
    check({tag, ".busy_done"}, 64'(busy_o),      64'd1);
    tick();
    check({tag, ".valid_1cyc"}, 64'(valid_o), 64'd0);
    check({tag, ".busy_idle"},  64'(busy_o),  64'd0);
  endtask

  initial begin
    int v0;
    int t0;
    rst_ni = 1'b0;
    en_i   = 1'b0;
    cmd_i  = 1'b1;
    #12;
    check("rst.busy",      64'(busy_o),      64'd0);
    check("rst.resp",      64'(resp_o),      64'd0);
    check("rst.crc",       64'(crc_o),       64'd0);
    check("rst.crc_ok",    64'(crc_ok_o),    64'd0);
    check("rst.frame_err", 64'(frame_err_o), 64'd0);
    check("rst.valid",     64'(valid_o),     64'd0);
    check("rst.timeout",   64'(timeout_o),   64'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Good frame, CRC 0x33 from the reference, 5 idle-high cycles first.
    send_frame(40'h1100000900, 7'h33, 1'b1, 5);
    expect_valid("good");
    check("good.crc_ref", 64'(crc7_model(40'h1100000900)), 64'h33);

    // Same frame, corrupted CRC; re-armed in the first idle cycle.
    send_frame(40'h1100000900, 7'h32, 1'b1, 0);
    expect_valid("badcrc");

    // Transmission bit set, CRC correct.
    send_frame(40'h4000000000, 7'h4A, 1'b1, 2);
    expect_valid("txbit");
    check("txbit.crc_ref", 64'(crc7_model(40'h4000000000)), 64'h4A);

    // Timeout: cmd_i stays high after arming.
    v0 = valid_cnt;
    t0 = timeout_cnt;
    arm(TIMEOUT_CYC - 1);
    check("tmo.early_pulse", 64'(timeout_o), 64'd0);
    check("tmo.early_busy",  64'(busy_o),    64'd1);
    tick();
    check("tmo.pulse",      64'(timeout_o), 64'd1);
    check("tmo.busy",       64'(busy_o),    64'd0);
    check("tmo.no_valid",   64'(valid_o),   64'd0);
    tick();
    check("tmo.pulse_1cyc", 64'(timeout_o), 64'd0);
    check("tmo.count",      64'(timeout_cnt - t0), 64'd1);
    check("tmo.valid_cnt",  64'(valid_cnt - v0),   64'd0);
    check("tmo.hold_resp",  64'(resp_o),    64'h4000000000);
    check("tmo.hold_err",   64'(frame_err_o), 64'd1);

    // Reset in the middle of a frame (after bits 0..19).
    arm(3);
    send_bits({40'h1100000900, 7'h33, 1'b1}, 20);
    rst_ni = 1'b0;
    #1;
    check("midrst.busy",   64'(busy_o),   64'd0);
    check("midrst.resp",   64'(resp_o),   64'd0);
    check("midrst.crc_ok", 64'(crc_ok_o), 64'd0);
    check("midrst.ferr",   64'(frame_err_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("midrst.idle", 64'(busy_o), 64'd0);

    send_frame(40'h1100000900, 7'h33, 1'b1, 4);
    expect_valid("postrst");

    // Bad end bit.
    send_frame(40'h1100000900, 7'h33, 1'b0, 1);
    expect_valid("endbit");

    check("sb.empty", 64'(sb_q.size()), 64'd0);
    check("valid.total", 64'(valid_cnt), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sd_cmd_rx.md
SD_CMD_RX -- requirements
Module: sd_cmd_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, meaning the maximum number of high cmd_i samples tolerated before a start bit (NCR window).
REQ-002 SHALL have port clk_i, input, 1, the single clock; cmd_i is sampled on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port en_i, input, 1, a one-cycle pulse that arms reception of one 48-bit response.
REQ-005 SHALL have port cmd_i, input, 1, the serial CMD line, MSB first, idle high.
REQ-006 SHALL have port busy_o, output, 1, high while the block is armed or receiving.
REQ-007 SHALL have port resp_o, output, 40, the first 40 frame bits (start, transmission, index, argument).
REQ-008 SHALL have port crc_o, output, 7, the CRC7 field as received.
REQ-009 SHALL have port crc_ok_o, output, 1, high when the computed CRC7 equals crc_o.
REQ-010 SHALL have port frame_err_o, output, 1, high when the transmission bit is not 0 or the end bit is not 1.
REQ-011 SHALL have port valid_o, output, 1, a one-cycle pulse marking resp_o, crc_o, crc_ok_o and frame_err_o as valid.
REQ-012 SHALL have port timeout_o, output, 1, a one-cycle pulse when no start bit arrives in time.

Function
REQ-013 SHALL implement the states IDLE, WAIT_START, RECV and DONE.
REQ-014 In IDLE, en_i=1 SHALL move the block to WAIT_START, clear the timeout counter and clear the CRC register; en_i is ignored in every other state.
REQ-015 In WAIT_START, cmd_i=0 SHALL be taken as the start bit (bit 0) and move the block to RECV with bit counter=1; each cmd_i=1 sample SHALL increment the timeout counter.
REQ-016 In WAIT_START, the TIMEOUT_CYC-th consecutive high sample SHALL move the block to IDLE and pulse timeout_o on the following cycle.
REQ-017 In RECV, the block SHALL shift one bit per cycle for bits 1..47; after bit 47 it SHALL move to DONE.
REQ-018 CRC7 SHALL use polynomial x^7+x^3+1 with initial value 0, serial MSB first, over frame bits 0..39 including the start bit; the update is fb=crc[6]^bit, crc={crc[5:0],1'b0}^(fb?7'h09:0).
REQ-019 Bits 40..46 SHALL be captured into crc_o and bit 47 SHALL be taken as the end bit.
REQ-020 In DONE, the block SHALL pulse valid_o for exactly one cycle, the cycle after bit 47 is sampled, then return to IDLE.
REQ-021 resp_o, crc_o, crc_ok_o and frame_err_o SHALL hold their values until the next valid_o; they are undefined while receiving only if never yet valid, in which case they read 0.
REQ-022 busy_o SHALL be 1 in WAIT_START, RECV and DONE, and 0 in IDLE; en_i may be re-pulsed in the cycle busy_o returns to 0.
REQ-023 valid_o and timeout_o SHALL never be high in the same cycle.

Reset
REQ-024 rst_ni=0 SHALL asynchronously force IDLE and set every output, counter and the CRC register to 0, including mid-frame; the partial frame is discarded.

Structure
REQ-025 Package sd_pkg SHALL hold the state typedef, CRC7_POLY=7'h09, FRAME_LEN=48 and CRC_LEN=7.
REQ-026 The bit-serial CRC7 engine SHALL be the sub-module crc7_serial (clk, rst_ni, clr, en, bit, crc).
REQ-027 The timeout counter width SHALL be $clog2(TIMEOUT_CYC+1).

Verification
REQ-028 Reset check: rst_ni=0 -> all outputs 0, busy_o=0.
REQ-029 Arm, then after 5 idle-high cycles send 40'h1100000900, CRC 7'h33 and end bit 1 -> one valid_o pulse with resp_o=40'h1100000900, crc_o=7'h33, crc_ok_o=1, frame_err_o=0.
REQ-030 Send the same frame with CRC 7'h32 -> crc_ok_o=0, frame_err_o=0.
REQ-031 Send 40'h4000000000, CRC 7'h4A, end bit 1 -> crc_ok_o=1 and frame_err_o=1 (transmission bit set).
REQ-032 Arm with cmd_i held high -> timeout_o pulses once after 64 high samples, no valid_o, busy_o=0.
REQ-033 Assert rst_ni at bit 20 of a frame, release, re-arm and send the REQ-029 frame -> correct result; end bit 0 gives frame_err_o=1.
